// File: rtl/gigatron_serial_tx.sv
// Gigatron serial game-controller transmitter.
// Takes one decoded PS/2 key byte and shifts it MSB first into the Gigatron
// input port. Frames are delimited by the Gigatron's VSYNC (latch) and bits
// are clocked by its HSYNC (pulse). The key is held for HOLD_FRAMES frames,
// then 0xFF is sent for GAP_FRAMES frames before the next key is accepted.
module gigatron_serial_tx #(
    parameter int   HOLD_FRAMES = 3,
    parameter int   GAP_FRAMES  = 2,
    parameter logic LATCH_POL   = 1'b0
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] ps2_data,
    input  logic       ps2_ready,
    output logic       ps2_sending,
    input  logic       gig_latch,
    input  logic       gig_pulse,
    output logic       gig_data,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, ARM, HOLD, GAP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  latch_sr, pulse_sr;
    logic        latch_evt, pulse_evt;
    logic        ready_q;
    logic [7:0]  data_q;
    logic        new_key;
    logic [7:0]  key_r;
    logic [7:0]  shreg;
    logic [7:0]  reload_val;
    logic [3:0]  frames, frames_nxt;
    logic [3:0]  bitcnt;
    logic        capture;

    // Two-flop synchronisers plus one extra stage for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            latch_sr <= {3{~LATCH_POL}};
            pulse_sr <= 3'b000;
        end else begin
            latch_sr <= {latch_sr[1:0], gig_latch};
            pulse_sr <= {pulse_sr[1:0], gig_pulse};
        end
    end

    assign latch_evt = (latch_sr[1] == LATCH_POL) && (latch_sr[2] != LATCH_POL);
    assign pulse_evt = pulse_sr[1] & ~pulse_sr[2];

    // Registered copies of the decoder outputs for change detection.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            data_q  <= 8'hFF;
        end else begin
            ready_q <= ps2_ready;
            data_q  <= ps2_data;
        end
    end

    assign new_key = ps2_ready & (~ready_q | (ps2_data != data_q));

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; also selects what a latch event reloads into shreg.
    always_comb begin
        state_nxt  = state;
        frames_nxt = frames;
        reload_val = 8'hFF;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (new_key) begin
                    capture   = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (latch_evt) begin
                    reload_val = key_r;
                    frames_nxt = 4'd1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (latch_evt) begin
                    if (frames == 4'(HOLD_FRAMES)) begin
                        reload_val = 8'hFF;
                        frames_nxt = 4'd1;
                        state_nxt  = GAP;
                    end else begin
                        reload_val = key_r;
                        frames_nxt = frames + 4'd1;
                    end
                end
            end
            GAP: begin
                if (latch_evt) begin
                    if (frames == 4'(GAP_FRAMES)) state_nxt = IDLE;
                    else                          frames_nxt = frames + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accepted key byte; only meaningful while not IDLE, so it needs no reset.
    always_ff @(posedge CLOCK_50) begin
        if (capture) key_r <= ps2_data;
    end

    // Shift register: a latch reloads it (and wins over a coincident pulse),
    // a pulse shifts in a 1 until eight bits have gone out.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            shreg     <= 8'hFF;
            bitcnt    <= 4'd0;
            frames    <= 4'd0;
            gig_data  <= 1'b1;
            frame_cnt <= 8'd0;
        end else begin
            frames   <= frames_nxt;
            gig_data <= shreg[7];
            if (latch_evt) begin
                shreg     <= reload_val;
                bitcnt    <= 4'd0;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (pulse_evt && (bitcnt != 4'd8)) begin
                shreg  <= {shreg[6:0], 1'b1};
                bitcnt <= bitcnt + 4'd1;
            end
        end
    end

    assign ps2_sending = (state != IDLE);

endmodule
